// File: rtl/ex_hazard_scoreboard_if.sv
// Decode <-> Execute issue-control bundle for ex_hazard_scoreboard.
//   master : Decode side, drives the instruction descriptor and pipe controls
//   slave  : scoreboard, returns grant/stall and pending-writer status
interface ex_hazard_scoreboard_if #(
  parameter int unsigned PIPE_DEPTH = 3,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned NUM_VREGS  = 64
);
  localparam int unsigned RIW = $clog2(NUM_REGS);
  localparam int unsigned VIW = $clog2(NUM_VREGS);
  localparam int unsigned CW  = $clog2(PIPE_DEPTH + 1);

  logic           I_LOCK;
  logic           I_GPUStallSignal;
  logic           I_Flush;
  logic           I_Issue_Req;
  logic [RIW-1:0] I_Src1Idx;
  logic [RIW-1:0] I_Src2Idx;
  logic           I_Src1Used;
  logic           I_Src2Used;
  logic [VIW-1:0] I_VSrc1Idx;
  logic [VIW-1:0] I_VSrc2Idx;
  logic           I_VSrc1Used;
  logic           I_VSrc2Used;
  logic           I_CCUsed;
  logic [RIW-1:0] I_DestRegIdx;
  logic           I_RegWEn;
  logic [VIW-1:0] I_DestVRegIdx;
  logic           I_VRegWEn;
  logic           I_CCWEn;

  logic                O_Issue_Grant;
  logic                O_DE_Stall;
  logic [NUM_REGS-1:0] O_PendingRegMask;
  logic                O_PendingCC;
  logic [CW-1:0]       O_InFlight;
  logic                O_Drained;

  modport master (
    output I_LOCK, I_GPUStallSignal, I_Flush, I_Issue_Req,
           I_Src1Idx, I_Src2Idx, I_Src1Used, I_Src2Used,
           I_VSrc1Idx, I_VSrc2Idx, I_VSrc1Used, I_VSrc2Used, I_CCUsed,
           I_DestRegIdx, I_RegWEn, I_DestVRegIdx, I_VRegWEn, I_CCWEn,
    input  O_Issue_Grant, O_DE_Stall, O_PendingRegMask, O_PendingCC,
           O_InFlight, O_Drained
  );

  modport slave (
    input  I_LOCK, I_GPUStallSignal, I_Flush, I_Issue_Req,
           I_Src1Idx, I_Src2Idx, I_Src1Used, I_Src2Used,
           I_VSrc1Idx, I_VSrc2Idx, I_VSrc1Used, I_VSrc2Used, I_CCUsed,
           I_DestRegIdx, I_RegWEn, I_DestVRegIdx, I_VRegWEn, I_CCWEn,
    output O_Issue_Grant, O_DE_Stall, O_PendingRegMask, O_PendingCC,
           O_InFlight, O_Drained
  );
endinterface

// File: rtl/ex_hazard_scoreboard.sv
// Execute-stage issue controller. Tracks in-flight scalar/vector/CC writers
// from EX issue to WB retire and grants or stalls the decoded instruction.
//   I_CLOCK   : clock, state updates on the falling edge
//   I_RESET_N : asynchronous active-low reset
//   bus       : issue-control bundle (slave side)
module ex_hazard_scoreboard #(
  parameter int unsigned PIPE_DEPTH = 3,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned NUM_VREGS  = 64
) (
  input logic                  I_CLOCK,
  input logic                  I_RESET_N,
  ex_hazard_scoreboard_if.slave bus
);
  localparam int unsigned RIW = $clog2(NUM_REGS);
  localparam int unsigned VIW = $clog2(NUM_VREGS);
  localparam int unsigned CW  = $clog2(PIPE_DEPTH + 1);

  typedef struct packed {
    logic           valid;
    logic           regwen;
    logic [RIW-1:0] ridx;
    logic           vregwen;
    logic [VIW-1:0] vidx;
    logic           ccwen;
  } entry_t;

  entry_t              pipe_q [PIPE_DEPTH];
  entry_t              pipe_d [PIPE_DEPTH];
  logic [CW-1:0]       cnt_q  [NUM_REGS];
  logic [CW-1:0]       cnt_d  [NUM_REGS];
  logic [CW-1:0]       vcnt_q [NUM_VREGS];
  logic [CW-1:0]       vcnt_d [NUM_VREGS];
  logic [CW-1:0]       cc_cnt_q, cc_cnt_d;
  logic [NUM_REGS-1:0] mask_q, mask_d;
  logic                pend_cc_q, pend_cc_d;
  logic [CW-1:0]       inflight_q, inflight_d;
  logic                drained_q, drained_d;

  logic   hazard, grant, stall, cnt_err;
  entry_t issue_e, retire_e;

  // Returns {error, next}; an illegal step holds the count instead of wrapping.
  function automatic logic [CW:0] bump(input logic [CW-1:0] c, input logic inc, input logic dec);
    logic [CW:0] r;
    r = {1'b0, c};
    if (inc && !dec) begin
      if (c == CW'(PIPE_DEPTH)) r[CW] = 1'b1;
      else r[CW-1:0] = c + 1'b1;
    end else if (dec && !inc) begin
      if (c == '0) r[CW] = 1'b1;
      else r[CW-1:0] = c - 1'b1;
    end
    return r;
  endfunction

  // Sources are checked against pre-edge counts, so self-dependence is not a hazard.
  always_comb begin
    hazard = (bus.I_Src1Used  && (cnt_q[bus.I_Src1Idx]   != '0)) ||
             (bus.I_Src2Used  && (cnt_q[bus.I_Src2Idx]   != '0)) ||
             (bus.I_VSrc1Used && (vcnt_q[bus.I_VSrc1Idx] != '0)) ||
             (bus.I_VSrc2Used && (vcnt_q[bus.I_VSrc2Idx] != '0)) ||
             (bus.I_CCUsed    && (cc_cnt_q != '0));
    grant = bus.I_Issue_Req && bus.I_LOCK && !bus.I_GPUStallSignal && !bus.I_Flush && !hazard;
    stall = bus.I_Issue_Req && bus.I_LOCK && !bus.I_Flush && (hazard || bus.I_GPUStallSignal);

    issue_e         = '0;
    issue_e.valid   = grant;
    issue_e.regwen  = grant && bus.I_RegWEn;
    issue_e.ridx    = bus.I_DestRegIdx;
    issue_e.vregwen = grant && bus.I_VRegWEn;
    issue_e.vidx    = bus.I_DestVRegIdx;
    issue_e.ccwen   = grant && bus.I_CCWEn;
    retire_e        = pipe_q[PIPE_DEPTH-1];
  end

  always_comb begin
    logic [CW:0] b;
    b        = '0;
    pipe_d   = pipe_q;
    cnt_d    = cnt_q;
    vcnt_d   = vcnt_q;
    cc_cnt_d = cc_cnt_q;
    cnt_err  = 1'b0;
    if (!bus.I_GPUStallSignal) begin
      pipe_d[0] = issue_e;
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) pipe_d[i] = pipe_q[i-1];
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        b = bump(cnt_q[i], issue_e.regwen && (issue_e.ridx == RIW'(i)),
                 retire_e.valid && retire_e.regwen && (retire_e.ridx == RIW'(i)));
        cnt_d[i] = b[CW-1:0];
        cnt_err  = cnt_err | b[CW];
      end
      for (int unsigned i = 0; i < NUM_VREGS; i++) begin
        b = bump(vcnt_q[i], issue_e.vregwen && (issue_e.vidx == VIW'(i)),
                 retire_e.valid && retire_e.vregwen && (retire_e.vidx == VIW'(i)));
        vcnt_d[i] = b[CW-1:0];
        cnt_err   = cnt_err | b[CW];
      end
      b = bump(cc_cnt_q, issue_e.ccwen, retire_e.valid && retire_e.ccwen);
      cc_cnt_d = b[CW-1:0];
      cnt_err  = cnt_err | b[CW];
    end

    for (int unsigned i = 0; i < NUM_REGS; i++) mask_d[i] = (cnt_d[i] != '0);
    pend_cc_d  = (cc_cnt_d != '0);
    inflight_d = '0;
    for (int unsigned i = 0; i < PIPE_DEPTH; i++) inflight_d = inflight_d + CW'(pipe_d[i].valid);
    drained_d = (inflight_d == '0);
  end

  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      pipe_q     <= '{default: '0};
      cnt_q      <= '{default: '0};
      vcnt_q     <= '{default: '0};
      cc_cnt_q   <= '0;
      mask_q     <= '0;
      pend_cc_q  <= 1'b0;
      inflight_q <= '0;
      drained_q  <= 1'b1;
    end else begin
      pipe_q     <= pipe_d;
      cnt_q      <= cnt_d;
      vcnt_q     <= vcnt_d;
      cc_cnt_q   <= cc_cnt_d;
      mask_q     <= mask_d;
      pend_cc_q  <= pend_cc_d;
      inflight_q <= inflight_d;
      drained_q  <= drained_d;
    end
  end

  assert property (@(negedge I_CLOCK) disable iff (!I_RESET_N) !cnt_err);

  assign bus.O_Issue_Grant    = grant;
  assign bus.O_DE_Stall       = stall;
  assign bus.O_PendingRegMask = mask_q;
  assign bus.O_PendingCC      = pend_cc_q;
  assign bus.O_InFlight       = inflight_q;
  assign bus.O_Drained        = drained_q;
endmodule

// File: tb/tb_ex_hazard_scoreboard.sv
module tb_ex_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_hazard_scoreboard_if #(.PIPE_DEPTH(3), .NUM_REGS(16), .NUM_VREGS(64)) bus ();
  ex_hazard_scoreboard #(.PIPE_DEPTH(3), .NUM_REGS(16), .NUM_VREGS(64)) dut (
    .I_CLOCK(clk), .I_RESET_N(rst_n), .bus(bus)
  );

  typedef struct {
    logic [3:0] s1; logic s1u; logic [3:0] s2; logic s2u;
    logic [5:0] v1; logic v1u; logic [5:0] v2; logic v2u; logic ccu;
    logic [3:0] rd; logic rwe; logic [5:0] vd; logic vwe; logic ccwe;
  } instr_t;

  typedef struct {
    string name; logic g; logic s; logic [15:0] m; logic c; logic [1:0] i;
  } exp_t;

  typedef struct {
    logic req; logic lock; logic gs; logic fl; instr_t ins; exp_t e;
  } vec_t;

  int tests = 0;
  int fails = 0;
  vec_t tbl[$];
  exp_t sb[$];

  function automatic instr_t nop(); instr_t x; x = '{default: '0}; return x; endfunction
  function automatic instr_t wr(int r); instr_t x; x = nop(); x.rd = 4'(r); x.rwe = 1; return x; endfunction
  function automatic instr_t add(int d, int a, int b);
    instr_t x; x = wr(d); x.s1 = 4'(a); x.s1u = 1; x.s2 = 4'(b); x.s2u = 1; return x;
  endfunction
  function automatic instr_t rd1(int r); instr_t x; x = nop(); x.s1 = 4'(r); x.s1u = 1; return x; endfunction
  function automatic instr_t vwr(int r); instr_t x; x = nop(); x.vd = 6'(r); x.vwe = 1; return x; endfunction
  function automatic instr_t vrd(int r); instr_t x; x = nop(); x.v1 = 6'(r); x.v1u = 1; return x; endfunction
  function automatic instr_t vrd2(int r); instr_t x; x = nop(); x.v2 = 6'(r); x.v2u = 1; return x; endfunction
  function automatic instr_t ccwr(); instr_t x; x = nop(); x.ccwe = 1; return x; endfunction
  function automatic instr_t ccrd(); instr_t x; x = nop(); x.ccu = 1; return x; endfunction

  function automatic vec_t v(string n, logic req, logic lock, logic gs, logic fl, instr_t ins,
                             logic g, logic s, logic [15:0] m, logic c, logic [1:0] i);
    vec_t x;
    x.req = req; x.lock = lock; x.gs = gs; x.fl = fl; x.ins = ins;
    x.e = '{name: n, g: g, s: s, m: m, c: c, i: i};
    return x;
  endfunction

  task automatic drive(input logic req, input logic lock, input logic gs, input logic fl, input instr_t x);
    bus.I_Issue_Req = req; bus.I_LOCK = lock; bus.I_GPUStallSignal = gs; bus.I_Flush = fl;
    bus.I_Src1Idx = x.s1; bus.I_Src1Used = x.s1u; bus.I_Src2Idx = x.s2; bus.I_Src2Used = x.s2u;
    bus.I_VSrc1Idx = x.v1; bus.I_VSrc1Used = x.v1u; bus.I_VSrc2Idx = x.v2; bus.I_VSrc2Used = x.v2u;
    bus.I_CCUsed = x.ccu; bus.I_DestRegIdx = x.rd; bus.I_RegWEn = x.rwe;
    bus.I_DestVRegIdx = x.vd; bus.I_VRegWEn = x.vwe; bus.I_CCWEn = x.ccwe;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk({e.name, " grant"},    32'(bus.O_Issue_Grant),    32'(e.g));
    chk({e.name, " stall"},    32'(bus.O_DE_Stall),       32'(e.s));
    chk({e.name, " mask"},     32'(bus.O_PendingRegMask), 32'(e.m));
    chk({e.name, " cc"},       32'(bus.O_PendingCC),      32'(e.c));
    chk({e.name, " inflight"}, 32'(bus.O_InFlight),       32'(e.i));
    chk({e.name, " drained"},  32'(bus.O_Drained),        32'(e.i == 2'd0));
  endtask

  initial begin
    // name                    req lk gs fl instr         g  s  mask      cc infl
    tbl.push_back(v("add_r1_self", 1, 1, 0, 0, add(1, 1, 2), 1, 0, 16'h0000, 0, 0));
    tbl.push_back(v("raw_r1_c1",   1, 1, 0, 0, rd1(1),       0, 1, 16'h0002, 0, 1));
    tbl.push_back(v("raw_r1_c2",   1, 1, 0, 0, rd1(1),       0, 1, 16'h0002, 0, 1));
    tbl.push_back(v("raw_r1_c3",   1, 1, 0, 0, rd1(1),       0, 1, 16'h0002, 0, 1));
    tbl.push_back(v("raw_r1_gnt",  1, 1, 0, 0, rd1(1),       1, 0, 16'h0000, 0, 0));
    tbl.push_back(v("movi_r2_a",   1, 1, 0, 0, wr(2),        1, 0, 16'h0000, 0, 1));
    tbl.push_back(v("movi_r2_b",   1, 1, 0, 0, wr(2),        1, 0, 16'h0004, 0, 2));
    tbl.push_back(v("raw_r2_c1",   1, 1, 0, 0, rd1(2),       0, 1, 16'h0004, 0, 3));
    tbl.push_back(v("raw_r2_c2",   1, 1, 0, 0, rd1(2),       0, 1, 16'h0004, 0, 2));
    tbl.push_back(v("raw_r2_c3",   1, 1, 0, 0, rd1(2),       0, 1, 16'h0004, 0, 1));
    tbl.push_back(v("raw_r2_gnt",  1, 1, 0, 0, rd1(2),       1, 0, 16'h0000, 0, 0));
    tbl.push_back(v("cmp",         1, 1, 0, 0, ccwr(),       1, 0, 16'h0000, 0, 1));
    tbl.push_back(v("brz_c1",      1, 1, 0, 0, ccrd(),       0, 1, 16'h0000, 1, 2));
    tbl.push_back(v("brz_c2",      1, 1, 0, 0, ccrd(),       0, 1, 16'h0000, 1, 2));
    tbl.push_back(v("brz_c3",      1, 1, 0, 0, ccrd(),       0, 1, 16'h0000, 1, 1));
    tbl.push_back(v("brz_gnt",     1, 1, 0, 0, ccrd(),       1, 0, 16'h0000, 0, 0));
    tbl.push_back(v("vadd_v5",     1, 1, 0, 0, vwr(5),       1, 0, 16'h0000, 0, 1));
    tbl.push_back(v("vmov_v6",     1, 1, 0, 0, vrd(6),       1, 0, 16'h0000, 0, 2));
    tbl.push_back(v("vmov_v5_c1",  1, 1, 0, 0, vrd(5),       0, 1, 16'h0000, 0, 3));
    tbl.push_back(v("vmov_v5_c2",  1, 1, 0, 0, vrd2(5),      0, 1, 16'h0000, 0, 2));
    tbl.push_back(v("vmov_v5_gnt", 1, 1, 0, 0, vrd(5),       1, 0, 16'h0000, 0, 1));
    tbl.push_back(v("flush_r4",    1, 1, 0, 1, wr(4),        0, 0, 16'h0000, 0, 1));
    tbl.push_back(v("idle_a",      0, 1, 0, 0, nop(),        0, 0, 16'h0000, 0, 1));
    tbl.push_back(v("idle_b",      0, 1, 0, 0, nop(),        0, 0, 16'h0000, 0, 1));
    tbl.push_back(v("idle_c",      0, 1, 0, 0, nop(),        0, 0, 16'h0000, 0, 0));
    tbl.push_back(v("nolock_r5",   1, 0, 0, 0, wr(5),        0, 0, 16'h0000, 0, 0));
    tbl.push_back(v("gstall_r6",   1, 1, 1, 0, wr(6),        0, 1, 16'h0000, 0, 0));
    tbl.push_back(v("wr_r3",       1, 1, 0, 0, wr(3),        1, 0, 16'h0000, 0, 0));
    tbl.push_back(v("nolock_mid",  1, 0, 0, 0, wr(11),       0, 0, 16'h0008, 0, 1));
    for (int k = 0; k < 5; k++)
      tbl.push_back(v($sformatf("gfreeze_%0d", k), 1, 1, 1, 0, rd1(7), 0, 1, 16'h0008, 0, 1));
    tbl.push_back(v("r3_adv1",     0, 1, 0, 0, nop(),        0, 0, 16'h0008, 0, 1));
    tbl.push_back(v("r3_adv2",     0, 1, 0, 0, nop(),        0, 0, 16'h0008, 0, 1));
    tbl.push_back(v("r3_gone",     0, 1, 0, 0, nop(),        0, 0, 16'h0000, 0, 0));
    tbl.push_back(v("wr_r9_a",     1, 1, 0, 0, wr(9),        1, 0, 16'h0000, 0, 0));
    tbl.push_back(v("r9_p1",       0, 1, 0, 0, nop(),        0, 0, 16'h0200, 0, 1));
    tbl.push_back(v("r9_p2",       0, 1, 0, 0, nop(),        0, 0, 16'h0200, 0, 1));
    tbl.push_back(v("wr_r9_b",     1, 1, 0, 0, wr(9),        1, 0, 16'h0200, 0, 1));
    tbl.push_back(v("r9_same_edge",0, 1, 0, 0, nop(),        0, 0, 16'h0200, 0, 1));
    tbl.push_back(v("r9_b_p1",     0, 1, 0, 0, nop(),        0, 0, 16'h0200, 0, 1));
    tbl.push_back(v("r9_b_p2",     0, 1, 0, 0, nop(),        0, 0, 16'h0200, 0, 1));
    tbl.push_back(v("r9_gone",     0, 1, 0, 0, nop(),        0, 0, 16'h0000, 0, 0));

    // Reset held with a pending request: state empty, grant follows comb rules.
    drive(1, 1, 0, 0, wr(1));
    repeat (3) @(negedge clk);
    #1;
    chk_all('{name: "reset_hold", g: 1, s: 0, m: 16'h0, c: 0, i: 2'd0});
    @(posedge clk);
    rst_n = 1'b1;
    #1;
    chk("release grant", 32'(bus.O_Issue_Grant), 32'd1);
    drive(0, 1, 0, 0, nop());

    foreach (tbl[k]) begin
      exp_t e;
      @(posedge clk);
      drive(tbl[k].req, tbl[k].lock, tbl[k].gs, tbl[k].fl, tbl[k].ins);
      sb.push_back(tbl[k].e);
      #1;
      e = sb.pop_front();
      chk_all(e);
    end

    // Three writers in flight, then an asynchronous reset clears everything at once.
    @(posedge clk); drive(1, 1, 0, 0, wr(10));
    @(posedge clk); drive(1, 1, 0, 0, ccwr());
    @(posedge clk); drive(1, 1, 0, 0, vwr(20));
    @(posedge clk); drive(0, 1, 0, 0, nop());
    #1;
    chk_all('{name: "full_pipe", g: 0, s: 0, m: 16'h0400, c: 1, i: 2'd3});
    #1 rst_n = 1'b0;
    #1;
    chk_all('{name: "mid_reset", g: 0, s: 0, m: 16'h0000, c: 0, i: 2'd0});
    @(posedge clk);
    rst_n = 1'b1;
    drive(1, 1, 0, 0, vrd(20));
    #1;
    chk("post_reset v20 grant", 32'(bus.O_Issue_Grant), 32'd1);
    drive(0, 1, 0, 0, nop());
    @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
